ad9866_spi_seq: RTL and testbench

AD9866_SPI_SEQ -- requirements
Module: ad9866_spi_seq

---
 rtl/ad9866_spi_seq.sv | 218 +++++++++++++++++++++
 tb/tb_ad9866_spi_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9866_spi_seq.sv
// AD9866 SPI write sequencer: hardware reset, power-up register table, then host
// register writes and RX PGA gain updates as 16-bit SPI write frames.
//
// state   | meaning
// RSTHOLD | ad9866_rst_n held low for RSTCYC cycles
// RSTWAIT | reset released, wait RSTCYC cycles before the first write
// IDLE    | init done, arbitrate host command over gain update
// LOAD    | frame latched, sen_n low, sdio = bit 15
// SHIFT   | 16 bits clocked out, CLKDIV cycles per SCLK half-period
// END     | sen_n high for CLKDIV cycles between frames
module ad9866_spi_seq #(
  parameter int               CLKDIV   = 4,
  parameter int               RSTCYC   = 64,
  parameter int               NINIT    = 4,
  parameter logic [NINIT*15-1:0] INITTAB = '0,
  parameter logic [6:0]       GAINADDR = 7'h09
) (
  input  logic       ad9866spiclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       cmd_ack,
  input  logic [5:0] rx_gain,
  output logic       init_done,
  output logic       busy,
  output logic       ad9866_rst_n,
  output logic       ad9866_sen_n,
  output logic       ad9866_sclk,
  output logic       ad9866_sdio
);

  localparam int CMAX = (RSTCYC > CLKDIV) ? RSTCYC : CLKDIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NINIT + 1);
  localparam logic [CW-1:0] RST_LD = CW'(RSTCYC - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(CLKDIV - 1);

  localparam logic [2:0] S_RSTHOLD = 3'd0;
  localparam logic [2:0] S_RSTWAIT = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_SHIFT   = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          is_init_q, is_init_d;
  logic [5:0]    last_gain_q, last_gain_d;
  logic          first_gain_q, first_gain_d;
  logic          init_done_q, init_done_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          rst_out_q, rst_out_d;
  logic          sen_n_q, sen_n_d;
  logic          sclk_q, sclk_d;
  logic          sdio_q, sdio_d;

  logic [14:0] init_entry;
  logic        gain_pend;
  logic        ld;
  logic [15:0] ld_frame;

  always_comb begin
    init_entry = '0;
    for (int i = 0; i < NINIT; i++) begin
      if (idx_q == IW'(i)) init_entry = INITTAB[i*15 +: 15];
    end
  end

  assign gain_pend = first_gain_q || (rx_gain != last_gain_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    is_init_d    = is_init_q;
    last_gain_d  = last_gain_q;
    first_gain_d = first_gain_q;
    init_done_d  = init_done_q;
    cmd_ack_d    = 1'b0;
    rst_out_d    = rst_out_q;
    sen_n_d      = sen_n_q;
    sclk_d       = sclk_q;
    sdio_d       = sdio_q;
    ld           = 1'b0;
    ld_frame     = '0;

    case (state_q)
      S_RSTHOLD: begin
        if (cnt_q == '0) begin
          state_d   = S_RSTWAIT;
          cnt_d     = RST_LD;
          rst_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RSTWAIT: begin
        if (cnt_q == '0) begin
          ld        = 1'b1;
          ld_frame  = {1'b0, init_entry};
          is_init_d = 1'b1;
          idx_d     = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          ld        = 1'b1;
          ld_frame  = {1'b0, cmd_addr, cmd_data};
          cmd_ack_d = 1'b1;
          is_init_d = 1'b0;
        end else if (gain_pend) begin
          ld           = 1'b1;
          ld_frame     = {1'b0, GAINADDR, 2'b01, rx_gain};
          last_gain_d  = rx_gain;
          first_gain_d = 1'b0;
          is_init_d    = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = DIV_LD;
        bit_d   = 4'd15;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = DIV_LD;
        end else if (bit_q == 4'd0) begin
          state_d = S_END;
          sclk_d  = 1'b0;
          sen_n_d = 1'b1;
          cnt_d   = DIV_LD;
        end else begin
          // data only moves on the falling SCLK edge
          bit_d  = bit_q - 4'd1;
          sclk_d = 1'b0;
          sdio_d = frame_q[bit_q - 4'd1];
          cnt_d  = DIV_LD;
        end
      end
      S_END: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (is_init_q && (idx_q != IW'(NINIT))) begin
          ld       = 1'b1;
          ld_frame = {1'b0, init_entry};
          idx_d    = idx_q + IW'(1);
        end else begin
          state_d   = S_IDLE;
          is_init_d = 1'b0;
          if (is_init_q) init_done_d = 1'b1;
        end
      end
      default: state_d = S_RSTHOLD;
    endcase

    if (ld) begin
      state_d = S_LOAD;
      frame_d = ld_frame;
      sen_n_d = 1'b0;
      sclk_d  = 1'b0;
      sdio_d  = ld_frame[15];
    end
  end

  always_ff @(posedge ad9866spiclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RSTHOLD;
      cnt_q        <= RST_LD;
      bit_q        <= 4'd15;
      frame_q      <= '0;
      idx_q        <= '0;
      is_init_q    <= 1'b0;
      last_gain_q  <= '0;
      first_gain_q <= 1'b1;
      init_done_q  <= 1'b0;
      cmd_ack_q    <= 1'b0;
      rst_out_q    <= 1'b0;
      sen_n_q      <= 1'b1;
      sclk_q       <= 1'b0;
      sdio_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      is_init_q    <= is_init_d;
      last_gain_q  <= last_gain_d;
      first_gain_q <= first_gain_d;
      init_done_q  <= init_done_d;
      cmd_ack_q    <= cmd_ack_d;
      rst_out_q    <= rst_out_d;
      sen_n_q      <= sen_n_d;
      sclk_q       <= sclk_d;
      sdio_q       <= sdio_d;
    end
  end

  assign cmd_ack      = cmd_ack_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != S_IDLE);
  assign ad9866_rst_n = rst_out_q;
  assign ad9866_sen_n = sen_n_q;
  assign ad9866_sclk  = sclk_q;
  assign ad9866_sdio  = sdio_q;

endmodule

// File: tb/tb_ad9866_spi_seq.sv
// Directed bench for ad9866_spi_seq: decodes SPI frames off the pins and checks
// reset, init replay, host/gain arbitration, latency and SCLK-edge data stability.
module tb_ad9866_spi_seq;

  localparam int CLKDIV = 2;
  localparam int RSTCYC = 8;
  localparam int NINIT  = 2;
  localparam logic [29:0] TAB = {7'h04, 8'h36, 7'h00, 8'h80};

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ack;
  logic [5:0] rx_gain;
  logic       init_done;
  logic       busy;
  logic       ad_rst_n;
  logic       sen_n;
  logic       sclk;
  logic       sdio;

  ad9866_spi_seq #(
    .CLKDIV(CLKDIV), .RSTCYC(RSTCYC), .NINIT(NINIT), .INITTAB(TAB), .GAINADDR(7'h09)
  ) dut (
    .ad9866spiclk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_ack(cmd_ack),
    .rx_gain(rx_gain),
    .init_done(init_done),
    .busy(busy),
    .ad9866_rst_n(ad_rst_n),
    .ad9866_sen_n(sen_n),
    .ad9866_sclk(sclk),
    .ad9866_sdio(sdio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] frames[$];
  logic [15:0] shreg = '0;
  int          nbits = 0;
  int          viol = 0;
  int          ack_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_sen = 1'b1;
  logic        prev_sdio = 1'b0;

  // pin-level frame decoder and SCLK-high stability watcher
  always @(negedge clk) begin
    if (!sen_n && prev_sen) begin
      nbits <= 0;
      shreg <= '0;
    end else if (!sen_n && sclk && !prev_sclk) begin
      shreg <= {shreg[14:0], sdio};
      nbits <= nbits + 1;
    end
    if (sen_n && !prev_sen && nbits == 16) frames.push_back(shreg);
    if (prev_sclk && sclk && (sdio !== prev_sdio || sen_n !== prev_sen)) viol <= viol + 1;
    if (cmd_ack) ack_cnt <= ack_cnt + 1;
    prev_sclk <= sclk;
    prev_sen  <= sen_n;
    prev_sdio <= sdio;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int base, input int nfr);
    int n;
    n = 0;
    while (!((frames.size() - base) >= nfr && !busy) && n < 3000) begin
      tick(1);
      n++;
    end
    total_cnt++;
    if (n >= 3000) $display("FAIL wait_idle timeout frames=%0d want=%0d", frames.size() - base, nfr);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    rx_gain = 6'h2A;
    tick(3);
    total_cnt++;
    if ({ad_rst_n, sen_n, sclk, sdio, cmd_ack, init_done, busy} !== 7'b0100001)
      $display("FAIL reset_outputs got %b want 0100001",
               {ad_rst_n, sen_n, sclk, sdio, cmd_ack, init_done, busy});
    else pass_cnt++;
  endtask

  task automatic test_init_sequence;
    int base;
    int n;
    base = frames.size();
    rst_n = 1'b1;
    tick(7);
    total_cnt++;
    if (ad_rst_n !== 1'b0) $display("FAIL rst_hold_7 got %b want 0", ad_rst_n);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (ad_rst_n !== 1'b1) $display("FAIL rst_release_8 got %b want 1", ad_rst_n);
    else pass_cnt++;
    tick(7);
    total_cnt++;
    if (sen_n !== 1'b1) $display("FAIL rst_wait_7 sen_n got %b want 1", sen_n);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (sen_n !== 1'b0) $display("FAIL first_load sen_n got %b want 0", sen_n);
    else pass_cnt++;
    n = 0;
    while (!init_done && n < 2000) begin
      tick(1);
      n++;
    end
    total_cnt++;
    if (init_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL init_done_rise got done=%b busy=%b want 1 0", init_done, busy);
    else pass_cnt++;
    total_cnt++;
    if ((frames.size() - base) != 2 || frames[base] !== 16'h0080 || frames[base+1] !== 16'h0436)
      $display("FAIL init_frames got n=%0d f0=%h f1=%h want 2 0080 0436", frames.size() - base,
               (frames.size() > base) ? frames[base] : 16'hxxxx,
               (frames.size() > base + 1) ? frames[base+1] : 16'hxxxx);
    else pass_cnt++;
    wait_idle(base, 3);
    total_cnt++;
    if ((frames.size() - base) < 3 || frames[base+2] !== 16'h096A)
      $display("FAIL first_gain_frame got %h want 096a",
               ((frames.size() - base) >= 3) ? frames[base+2] : 16'hxxxx);
    else pass_cnt++;
  endtask

  task automatic test_host_cmd;
    int base;
    int a0;
    int n;
    base = frames.size();
    a0 = ack_cnt;
    cmd_addr = 7'h0A;
    cmd_data = 8'h5C;
    cmd_valid = 1'b1;
    tick(1);
    total_cnt++;
    if (cmd_ack !== 1'b1 || sen_n !== 1'b0)
      $display("FAIL host_ack got ack=%b sen_n=%b want 1 0", cmd_ack, sen_n);
    else pass_cnt++;
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    total_cnt++;
    if (n != 67) $display("FAIL host_latency got %0d want 67", n);
    else pass_cnt++;
    tick(10);
    total_cnt++;
    if (busy !== 1'b0 || ack_cnt - a0 != 1)
      $display("FAIL host_after got busy=%b acks=%0d want 0 1", busy, ack_cnt - a0);
    else pass_cnt++;
    total_cnt++;
    if ((frames.size() - base) != 1 || frames[base] !== 16'h0A5C)
      $display("FAIL host_frame got n=%0d f=%h want 1 0a5c", frames.size() - base,
               (frames.size() > base) ? frames[base] : 16'hxxxx);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int base;
    int n;
    base = frames.size();
    cmd_addr = 7'h11;
    cmd_data = 8'hA5;
    cmd_valid = 1'b1;
    rx_gain = 6'h15;
    tick(1);
    total_cnt++;
    if (cmd_ack !== 1'b1) $display("FAIL b2b_ack got %b want 1", cmd_ack);
    else pass_cnt++;
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    tick(1);
    total_cnt++;
    if (n != 67 || busy !== 1'b1 || sen_n !== 1'b0)
      $display("FAIL b2b_gain_slot got lat=%0d busy=%b sen_n=%b want 67 1 0", n, busy, sen_n);
    else pass_cnt++;
    wait_idle(base, 2);
    tick(100);
    total_cnt++;
    if ((frames.size() - base) != 2 || frames[base] !== 16'h11A5 || frames[base+1] !== 16'h0955)
      $display("FAIL b2b_frames got n=%0d f0=%h f1=%h want 2 11a5 0955", frames.size() - base,
               (frames.size() > base) ? frames[base] : 16'hxxxx,
               (frames.size() > base + 1) ? frames[base+1] : 16'hxxxx);
    else pass_cnt++;
  endtask

  task automatic test_gain_coalesce;
    int base;
    base = frames.size();
    cmd_addr = 7'h3C;
    cmd_data = 8'h0F;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    rx_gain = 6'h10;
    tick(10);
    rx_gain = 6'h11;
    tick(10);
    rx_gain = 6'h12;
    wait_idle(base, 2);
    tick(100);
    total_cnt++;
    if ((frames.size() - base) != 2 || frames[base] !== 16'h3C0F || frames[base+1] !== 16'h0952)
      $display("FAIL gain_coalesce got n=%0d f0=%h f1=%h want 2 3c0f 0952", frames.size() - base,
               (frames.size() > base) ? frames[base] : 16'hxxxx,
               (frames.size() > base + 1) ? frames[base+1] : 16'hxxxx);
    else pass_cnt++;
  endtask

  task automatic test_cmd_withdraw;
    int base;
    int a0;
    base = frames.size();
    a0 = ack_cnt;
    cmd_addr = 7'h22;
    cmd_data = 8'h33;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(5);
    cmd_addr = 7'h55;
    cmd_data = 8'h66;
    cmd_valid = 1'b1;
    tick(20);
    cmd_valid = 1'b0;
    wait_idle(base, 1);
    tick(100);
    total_cnt++;
    if (ack_cnt - a0 != 1 || (frames.size() - base) != 1 || frames[base] !== 16'h2233)
      $display("FAIL cmd_withdraw got acks=%0d n=%0d f0=%h want 1 1 2233", ack_cnt - a0,
               frames.size() - base, (frames.size() > base) ? frames[base] : 16'hxxxx);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int base;
    int n;
    cmd_addr = 7'h0A;
    cmd_data = 8'h5C;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(35);
    total_cnt++;
    if (sclk !== 1'b1 || sen_n !== 1'b0)
      $display("FAIL bit7_high got sclk=%b sen_n=%b want 1 0", sclk, sen_n);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({sen_n, sclk, ad_rst_n, busy, init_done, cmd_ack} !== 6'b100100)
      $display("FAIL async_reset got %b want 100100", {sen_n, sclk, ad_rst_n, busy, init_done, cmd_ack});
    else pass_cnt++;
    tick(3);
    base = frames.size();
    rst_n = 1'b1;
    cmd_addr = 7'h7F;
    cmd_data = 8'h01;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ack && n < 2000) begin
      tick(1);
      n++;
    end
    cmd_valid = 1'b0;
    total_cnt++;
    if (cmd_ack !== 1'b1 || init_done !== 1'b1 || (frames.size() - base) != 2)
      $display("FAIL replay_host_after_init got ack=%b done=%b n=%0d want 1 1 2",
               cmd_ack, init_done, frames.size() - base);
    else pass_cnt++;
    wait_idle(base, 4);
    tick(50);
    total_cnt++;
    if ((frames.size() - base) != 4 || frames[base] !== 16'h0080 || frames[base+1] !== 16'h0436 ||
        frames[base+2] !== 16'h7F01 || frames[base+3] !== 16'h0952)
      $display("FAIL replay_frames got n=%0d want 4 frames 0080 0436 7f01 0952", frames.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_sclk_stability;
    total_cnt++;
    if (viol != 0) $display("FAIL sclk_high_stability got %0d violations want 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_host_cmd();
    test_back_to_back();
    test_gain_coalesce();
    test_cmd_withdraw();
    test_reset_mid_frame();
    test_sclk_stability();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
